// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: decodes Instr and sequences fetch/decode/execute with a MemReady handshake.
// Optional RETIRE_COUNT_EN adds a 32-bit RetireCount output of PC-updating cycles.
module multicycle_controller #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic        Zero,
    input  logic        MemReady,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic [1:0]  ImmSrc,
    output logic [3:0]  ALUControl,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        Illegal,
    output logic        MemErr,
    output logic [3:0]  State
`ifdef RETIRE_COUNT_EN
    ,
    output logic [31:0] RetireCount
`endif
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXEC_R    = 4'd3,
        S_EXEC_I    = 4'd4,
        S_MEM_ADR_L = 4'd5,
        S_MEM_WB    = 4'd6,
        S_MEM_ADR_S = 4'd7,
        S_BEQ       = 4'd8,
        S_JAL       = 4'd9,
        S_ERROR     = 4'd10
    } state_t;

    localparam logic [8:0] TIMEOUT_C = 9'(MEM_TIMEOUT);
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0101;

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       illegal_q, illegal_d;
    logic       mem_err_q, mem_err_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       f3_ok;
    logic       r_ok;
    logic       timeout;
    logic [3:0] alu_f3;
    logic       unused_instr_bits;

    assign opcode = Instr[6:0];
    assign funct3 = Instr[14:12];
    assign funct7 = Instr[31:25];
    assign unused_instr_bits = ^{Instr[24:15], Instr[11:7]};

    assign f3_ok = (funct3 == 3'b000) || (funct3 == 3'b111) ||
                   (funct3 == 3'b110) || (funct3 == 3'b010);
    // SUB is the only R-type encoding with a non-zero funct7.
    assign r_ok  = f3_ok && ((funct7 == 7'b0000000) ||
                             (funct7 == 7'b0100000 && funct3 == 3'b000));
    assign timeout = ({1'b0, wait_q} + 9'd1) == TIMEOUT_C;

    always_comb begin
        alu_f3 = ALU_ADD;
        case (funct3)
            3'b111:  alu_f3 = ALU_AND;
            3'b110:  alu_f3 = ALU_OR;
            3'b010:  alu_f3 = ALU_SLT;
            default: alu_f3 = ALU_ADD;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = 8'd0;
        illegal_d = illegal_q;
        mem_err_d = mem_err_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH, S_MEM_ADR_L, S_MEM_ADR_S: begin
                if (MemReady) begin
                    state_d = (state_q == S_FETCH)     ? S_DECODE :
                              (state_q == S_MEM_ADR_L) ? S_MEM_WB : S_FETCH;
                end else if (timeout) begin
                    state_d   = S_ERROR;
                    mem_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                state_d   = S_ERROR;
                illegal_d = 1'b1;
                if (opcode == 7'b0110011 && r_ok) begin
                    state_d = S_EXEC_R; illegal_d = illegal_q;
                end else if (opcode == 7'b0010011 && f3_ok) begin
                    state_d = S_EXEC_I; illegal_d = illegal_q;
                end else if (opcode == 7'b0000011 && funct3 == 3'b010) begin
                    state_d = S_MEM_ADR_L; illegal_d = illegal_q;
                end else if (opcode == 7'b0100011 && funct3 == 3'b010) begin
                    state_d = S_MEM_ADR_S; illegal_d = illegal_q;
                end else if (opcode == 7'b1100011 && funct3 == 3'b000) begin
                    state_d = S_BEQ; illegal_d = illegal_q;
                end else if (opcode == 7'b1101111) begin
                    state_d = S_JAL; illegal_d = illegal_q;
                end
            end
            S_EXEC_R, S_EXEC_I, S_MEM_WB, S_BEQ, S_JAL: state_d = S_FETCH;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase
    end

    always_comb begin
        ResultSrc  = 2'b00;
        ALUSrc     = 1'b0;
        RegWrite   = 1'b0;
        ImmSrc     = 2'b00;
        ALUControl = ALU_ADD;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        PCSrc      = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = MemReady;
            end
            S_DECODE: begin
                case (opcode)
                    7'b0100011: ImmSrc = 2'b01;
                    7'b1100011: ImmSrc = 2'b10;
                    7'b1101111: ImmSrc = 2'b11;
                    default:    ImmSrc = 2'b00;
                endcase
            end
            S_EXEC_R: begin
                ALUControl = (funct3 == 3'b000) ? (funct7[5] ? ALU_SUB : ALU_ADD) : alu_f3;
                RegWrite   = 1'b1;
                PCWrite    = 1'b1;
            end
            S_EXEC_I: begin
                ALUSrc     = 1'b1;
                ALUControl = alu_f3;
                RegWrite   = 1'b1;
                PCWrite    = 1'b1;
            end
            S_MEM_ADR_L: begin
                ALUSrc  = 1'b1;
                MemRead = 1'b1;
            end
            S_MEM_WB: begin
                ResultSrc = 2'b01;
                ALUSrc    = 1'b1;
                RegWrite  = 1'b1;
                PCWrite   = 1'b1;
            end
            S_MEM_ADR_S: begin
                ALUSrc   = 1'b1;
                ImmSrc   = 2'b01;
                MemWrite = 1'b1;
                PCWrite  = MemReady;
            end
            S_BEQ: begin
                ALUControl = ALU_SUB;
                ImmSrc     = 2'b10;
                PCWrite    = 1'b1;
                PCSrc      = Zero;
            end
            S_JAL: begin
                ImmSrc    = 2'b11;
                ResultSrc = 2'b10;
                RegWrite  = 1'b1;
                PCWrite   = 1'b1;
                PCSrc     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            wait_q    <= 8'd0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            mem_err_q <= mem_err_d;
        end
    end

`ifdef RETIRE_COUNT_EN
    logic [31:0] retire_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_q <= 32'd0;
        end else if (PCWrite && state_q != S_IDLE && state_q != S_ERROR) begin
            retire_q <= retire_q + 32'd1;
        end
    end

    assign RetireCount = retire_q;
`endif

    assign Illegal = illegal_q;
    assign MemErr  = mem_err_q;
    assign State   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: expected control vectors are queued per step and compared on the DUT outputs.
module tb_multicycle_controller;

    localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2, ST_EXEC_R = 4'd3,
                           ST_EXEC_I = 4'd4, ST_MEM_ADR_L = 4'd5, ST_MEM_WB = 4'd6,
                           ST_MEM_ADR_S = 4'd7, ST_BEQ = 4'd8, ST_JAL = 4'd9, ST_ERROR = 4'd10;
    localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic        Zero;
    logic        MemReady;
    logic [1:0]  ResultSrc;
    logic        ALUSrc;
    logic        RegWrite;
    logic [1:0]  ImmSrc;
    logic [3:0]  ALUControl;
    logic        MemRead;
    logic        MemWrite;
    logic        IRWrite;
    logic        PCWrite;
    logic        PCSrc;
    logic        Illegal;
    logic        MemErr;
    logic [3:0]  State;
`ifdef RETIRE_COUNT_EN
    logic [31:0] RetireCount;
`endif

    logic [20:0] exp_q[$];
    string       tag_q[$];
    int          checks = 0;
    int          errors = 0;

    multicycle_controller #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .Zero(Zero), .MemReady(MemReady),
        .ResultSrc(ResultSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .Illegal(Illegal), .MemErr(MemErr), .State(State)
`ifdef RETIRE_COUNT_EN
        , .RetireCount(RetireCount)
`endif
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: observed no end of run, required finish before 50000");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [20:0] e(input logic [3:0] st, input logic [1:0] rs, input logic asrc,
                                      input logic rw, input logic [1:0] imm, input logic [3:0] alu,
                                      input logic mr, input logic mw, input logic irw, input logic pcw,
                                      input logic pcs, input logic ill, input logic merr);
        return {st, rs, asrc, rw, imm, alu, mr, mw, irw, pcw, pcs, ill, merr};
    endfunction

    // scoreboard
    task automatic push(input logic [20:0] val, input string tag);
        exp_q.push_back(val);
        tag_q.push_back(tag);
    endtask

    task automatic compare_out();
        logic [20:0] obs;
        logic [20:0] want;
        string       tag;
        #1;
        obs = {State, ResultSrc, ALUSrc, RegWrite, ImmSrc, ALUControl,
               MemRead, MemWrite, IRWrite, PCWrite, PCSrc, Illegal, MemErr};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h with no expected entry", obs);
        end else begin
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            assert (obs === want) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, want);
            end
        end
    endtask

    // driver tasks
    task automatic check_only(input logic [20:0] val, input string tag);
        push(val, tag);
        compare_out();
    endtask

    task automatic step(input logic [20:0] val, input string tag);
        push(val, tag);
        compare_out();
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(e(ST_IDLE, 0, 0, 0, 0, ADD, 0, 0, 0, 0, 0, 0, 0), "idle_release");
    endtask

    initial begin
        reset    = 1'b0;
        Instr    = 32'h00500093;
        Zero     = 1'b0;
        MemReady = 1'b1;
        @(posedge clk);
        #1;
        check_only(e(ST_IDLE, 0, 0, 0, 0, ADD, 0, 0, 0, 0, 0, 0, 0), "reset_idle");
        release_reset();

        // addi x1, x0, 5
        step(e(ST_FETCH, 0, 0, 0, 0, ADD, 1, 0, 1, 0, 0, 0, 0), "addi_fetch");
        step(e(ST_DECODE, 0, 0, 0, 2'b00, ADD, 0, 0, 0, 0, 0, 0, 0), "addi_decode");
        step(e(ST_EXEC_I, 0, 1, 1, 2'b00, ADD, 0, 0, 0, 1, 0, 0, 0), "addi_exec");

        Instr = 32'h002081B3;
        step(e(ST_FETCH, 0, 0, 0, 0, ADD, 1, 0, 1, 0, 0, 0, 0), "add_fetch");
        step(e(ST_DECODE, 0, 0, 0, 2'b00, ADD, 0, 0, 0, 0, 0, 0, 0), "add_decode");
        step(e(ST_EXEC_R, 0, 0, 1, 2'b00, ADD, 0, 0, 0, 1, 0, 0, 0), "add_exec");

        Instr = 32'h402081B3;
        step(e(ST_FETCH, 0, 0, 0, 0, ADD, 1, 0, 1, 0, 0, 0, 0), "sub_fetch");
        step(e(ST_DECODE, 0, 0, 0, 2'b00, ADD, 0, 0, 0, 0, 0, 0, 0), "sub_decode");
        step(e(ST_EXEC_R, 0, 0, 1, 2'b00, SUB, 0, 0, 0, 1, 0, 0, 0), "sub_exec");

        // lw x5, 8(x0) with three stalled memory cycles
        Instr = 32'h00802283;
        step(e(ST_FETCH, 0, 0, 0, 0, ADD, 1, 0, 1, 0, 0, 0, 0), "lw_fetch");
        step(e(ST_DECODE, 0, 0, 0, 2'b00, ADD, 0, 0, 0, 0, 0, 0, 0), "lw_decode");
        MemReady = 1'b0;
        for (int i = 0; i < 3; i++)
            step(e(ST_MEM_ADR_L, 0, 1, 0, 2'b00, ADD, 1, 0, 0, 0, 0, 0, 0), "lw_wait");
        MemReady = 1'b1;
        step(e(ST_MEM_ADR_L, 0, 1, 0, 2'b00, ADD, 1, 0, 0, 0, 0, 0, 0), "lw_ready");
        step(e(ST_MEM_WB, 2'b01, 1, 1, 2'b00, ADD, 0, 0, 0, 1, 0, 0, 0), "lw_wb");

        // sw x1, 8(x3): PCWrite follows MemReady
        Instr = 32'h0011A423;
        step(e(ST_FETCH, 0, 0, 0, 0, ADD, 1, 0, 1, 0, 0, 0, 0), "sw_fetch");
        step(e(ST_DECODE, 0, 0, 0, 2'b01, ADD, 0, 0, 0, 0, 0, 0, 0), "sw_decode");
        MemReady = 1'b0;
        for (int i = 0; i < 2; i++)
            step(e(ST_MEM_ADR_S, 0, 1, 0, 2'b01, ADD, 0, 1, 0, 0, 0, 0, 0), "sw_wait");
        MemReady = 1'b1;
        step(e(ST_MEM_ADR_S, 0, 1, 0, 2'b01, ADD, 0, 1, 0, 1, 0, 0, 0), "sw_ready");

        // beq taken then not taken
        Instr = 32'h00208463;
        Zero  = 1'b1;
        step(e(ST_FETCH, 0, 0, 0, 0, ADD, 1, 0, 1, 0, 0, 0, 0), "beq1_fetch");
        step(e(ST_DECODE, 0, 0, 0, 2'b10, ADD, 0, 0, 0, 0, 0, 0, 0), "beq1_decode");
        step(e(ST_BEQ, 0, 0, 0, 2'b10, SUB, 0, 0, 0, 1, 1, 0, 0), "beq_taken");
        Zero = 1'b0;
        step(e(ST_FETCH, 0, 0, 0, 0, ADD, 1, 0, 1, 0, 0, 0, 0), "beq2_fetch");
        step(e(ST_DECODE, 0, 0, 0, 2'b10, ADD, 0, 0, 0, 0, 0, 0, 0), "beq2_decode");
        step(e(ST_BEQ, 0, 0, 0, 2'b10, SUB, 0, 0, 0, 1, 0, 0, 0), "beq_not_taken");

        // jal x1, 8
        Instr = 32'h008000EF;
        step(e(ST_FETCH, 0, 0, 0, 0, ADD, 1, 0, 1, 0, 0, 0, 0), "jal_fetch");
        step(e(ST_DECODE, 0, 0, 0, 2'b11, ADD, 0, 0, 0, 0, 0, 0, 0), "jal_decode");
        step(e(ST_JAL, 2'b10, 0, 1, 2'b11, ADD, 0, 0, 0, 1, 1, 0, 0), "jal_exec");

        // reset in the middle of a store drops MemWrite at once
        Instr = 32'h0011A423;
        step(e(ST_FETCH, 0, 0, 0, 0, ADD, 1, 0, 1, 0, 0, 0, 0), "abort_fetch");
        step(e(ST_DECODE, 0, 0, 0, 2'b01, ADD, 0, 0, 0, 0, 0, 0, 0), "abort_decode");
        MemReady = 1'b0;
        check_only(e(ST_MEM_ADR_S, 0, 1, 0, 2'b01, ADD, 0, 1, 0, 0, 0, 0, 0), "abort_store");
        reset = 1'b0;
        check_only(e(ST_IDLE, 0, 0, 0, 0, ADD, 0, 0, 0, 0, 0, 0, 0), "abort_reset");
        MemReady = 1'b1;
        release_reset();

        // illegal instruction, held in ERROR regardless of inputs
        Instr = 32'hFFFFFFFF;
        step(e(ST_FETCH, 0, 0, 0, 0, ADD, 1, 0, 1, 0, 0, 0, 0), "ill_fetch");
        step(e(ST_DECODE, 0, 0, 0, 2'b00, ADD, 0, 0, 0, 0, 0, 0, 0), "ill_decode");
        for (int i = 0; i < 20; i++) begin
            MemReady = 1'($urandom_range(0, 1));
            Zero     = 1'($urandom_range(0, 1));
            step(e(ST_ERROR, 0, 0, 0, 0, ADD, 0, 0, 0, 0, 0, 1, 0), "ill_hold");
        end
        reset = 1'b0;
        check_only(e(ST_IDLE, 0, 0, 0, 0, ADD, 0, 0, 0, 0, 0, 0, 0), "ill_reset");
        release_reset();

        // MemReady timeout in FETCH after exactly 15 wait cycles
        Instr    = 32'h00500093;
        MemReady = 1'b0;
        for (int i = 0; i < 15; i++)
            step(e(ST_FETCH, 0, 0, 0, 0, ADD, 1, 0, 0, 0, 0, 0, 0), "timeout_wait");
        check_only(e(ST_ERROR, 0, 0, 0, 0, ADD, 0, 0, 0, 0, 0, 0, 1), "timeout_error");
        reset = 1'b0;
        check_only(e(ST_IDLE, 0, 0, 0, 0, ADD, 0, 0, 0, 0, 0, 0, 0), "memerr_reset");
        release_reset();

        // MemReady on the final allowed wait cycle wins
        for (int i = 0; i < 14; i++)
            step(e(ST_FETCH, 0, 0, 0, 0, ADD, 1, 0, 0, 0, 0, 0, 0), "limit_wait");
        MemReady = 1'b1;
        step(e(ST_FETCH, 0, 0, 0, 0, ADD, 1, 0, 1, 0, 0, 0, 0), "limit_ready");
        check_only(e(ST_DECODE, 0, 0, 0, 2'b00, ADD, 0, 0, 0, 0, 0, 0, 0), "limit_decode");

        // final report
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: observed %0d entries, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
